// File: rtl/sc_io_hex_out.sv
// rtl/sc_io_hex_out.sv - memory-mapped output ports driving six 7-segment displays
// Stores are captured per port and converted to two decimal digits by one shared double-dabble engine.
module sc_io_hex_out #(
  parameter logic [7:0] ADDR_P0 = 8'h80,
  parameter logic [7:0] ADDR_P1 = 8'h84,
  parameter logic [7:0] ADDR_P2 = 8'h88
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] p0_q, p1_q, p2_q;
  logic [2:0]  pending_q, pending_d;
  logic [1:0]  sel_q;
  logic [6:0]  bin_q;
  logic [7:0]  bcd_q;
  logic [2:0]  cnt_q;
  logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;

  logic [2:0]  wr_sel;
  logic [2:0]  clr_mask;
  logic [1:0]  pick;
  logic [31:0] pick_val;
  logic [6:0]  clamp_val;
  logic [7:0]  bcd_adj;
  logic [7:0]  bcd_sh;
  logic [6:0]  bin_sh;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    wr_sel[0] = wmem && (addr == ADDR_P0);
    wr_sel[1] = wmem && (addr == ADDR_P1);
    wr_sel[2] = wmem && (addr == ADDR_P2);

    rdata = 32'd0;
    if (addr == ADDR_P0)      rdata = p0_q;
    else if (addr == ADDR_P1) rdata = p1_q;
    else if (addr == ADDR_P2) rdata = p2_q;

    if (pending_q[0])      pick = 2'd0;
    else if (pending_q[1]) pick = 2'd1;
    else                   pick = 2'd2;

    case (pick)
      2'd0:    pick_val = p0_q;
      2'd1:    pick_val = p1_q;
      default: pick_val = p2_q;
    endcase
    clamp_val = (pick_val > 32'd99) ? 7'd99 : pick_val[6:0];

    clr_mask = 3'b000;
    if (state_q == S_IDLE && (|pending_q)) clr_mask = 3'b001 << pick;
    // A store landing on the same edge as the clear keeps the port pending.
    pending_d = (pending_q & ~clr_mask) | wr_sel;

    bcd_adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    bcd_sh = {bcd_adj[6:0], bin_q[6]};
    bin_sh = {bin_q[5:0], 1'b0};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_q <= 32'd0;
      p1_q <= 32'd0;
      p2_q <= 32'd0;
    end else begin
      if (wr_sel[0]) p0_q <= wdata;
      if (wr_sel[1]) p1_q <= wdata;
      if (wr_sel[2]) p2_q <= wdata;
    end
  end

  // The load work (select, clamp, clear accumulator) happens on the edge entering LOAD,
  // so the seven shifts land on the following seven edges and the digits on the next.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 3'b000;
      sel_q     <= 2'd0;
      bin_q     <= 7'd0;
      bcd_q     <= 8'd0;
      cnt_q     <= 3'd0;
      hex0_q    <= 7'h7F;
      hex1_q    <= 7'h7F;
      hex2_q    <= 7'h7F;
      hex3_q    <= 7'h7F;
      hex4_q    <= 7'h7F;
      hex5_q    <= 7'h7F;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            sel_q   <= pick;
            bin_q   <= clamp_val;
            bcd_q   <= 8'd0;
            cnt_q   <= 3'd7;
            state_q <= S_LOAD;
          end
        end
        S_LOAD, S_SHIFT: begin
          if (cnt_q == 3'd0) begin
            case (sel_q)
              2'd0: begin
                hex1_q <= seg7(bcd_q[7:4]);
                hex0_q <= seg7(bcd_q[3:0]);
              end
              2'd1: begin
                hex3_q <= seg7(bcd_q[7:4]);
                hex2_q <= seg7(bcd_q[3:0]);
              end
              default: begin
                hex5_q <= seg7(bcd_q[7:4]);
                hex4_q <= seg7(bcd_q[3:0]);
              end
            endcase
            state_q <= S_STORE;
          end else begin
            bcd_q   <= bcd_sh;
            bin_q   <= bin_sh;
            cnt_q   <= cnt_q - 3'd1;
            state_q <= S_SHIFT;
          end
        end
        S_STORE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign hex0 = hex0_q;
  assign hex1 = hex1_q;
  assign hex2 = hex2_q;
  assign hex3 = hex3_q;
  assign hex4 = hex4_q;
  assign hex5 = hex5_q;

endmodule

// File: tb/tb_sc_io_hex_out.sv
// tb/tb_sc_io_hex_out.sv - self-checking bench for sc_io_hex_out
// Directed scenarios plus randomized stores, checked against a decimal-arithmetic display model.
module tb_sc_io_hex_out;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wmem;
  logic [31:0] rdata;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int tests = 0;
  int fails = 0;

  logic [6:0] segtab [10];
  logic [7:0] port_addr [3];
  int         disp [3];

  sc_io_hex_out dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wmem(wmem),
    .rdata(rdata), .busy(busy),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input logic [31:0] d);
    return (d > 32'd99) ? 99 : int'(d);
  endfunction

  function automatic logic [13:0] exp_pair(input int v);
    if (v < 0) return 14'h3FFF;
    return {segtab[v / 10], segtab[v % 10]};
  endfunction

  function automatic logic [13:0] obs_pair(input int i);
    case (i)
      0:       return {hex1, hex0};
      1:       return {hex3, hex2};
      default: return {hex5, hex4};
    endcase
  endfunction

  task automatic do_write(input int port, input logic [31:0] d);
    @(negedge clock);
    addr = port_addr[port];
    wdata = d;
    wmem = 1'b1;
    @(posedge clock);
    #1 wmem = 1'b0;
  endtask

  task automatic chk_all_blank(input string tag);
    for (int i = 0; i < 3; i++) chk(tag, {18'd0, obs_pair(i)}, 32'h3FFF);
  endtask

  initial begin
    int nbusy, first_busy, upd, upd2, port, nwr;
    logic [31:0] v, v2;

    segtab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    port_addr = '{8'h80, 8'h84, 8'h88};
    disp = '{-1, -1, -1};

    reset = 1'b1; addr = 8'h00; wdata = 32'd0; wmem = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_blank("reset_hex");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      addr = (i < 3) ? port_addr[i] : 8'h40;
      #1 chk("reset_rdata", rdata, 32'd0);
    end
    @(negedge clock) reset = 1'b0;

    // Single conversion: busy window and display update edge
    do_write(0, 32'd37);
    chk("rdata_p0_after_write", rdata, 32'd37);
    nbusy = 0; first_busy = -1; upd = -1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clock); #1;
      if (busy) begin
        nbusy++;
        if (first_busy < 0) first_busy = j;
      end
      if (upd < 0 && obs_pair(0) === exp_pair(37)) upd = j;
    end
    disp[0] = 37;
    chk("single_busy_cycles", nbusy, 9);
    chk("single_busy_start", first_busy, 1);
    chk("single_update_edge", upd, 9);
    chk("single_hex10", {18'd0, obs_pair(0)}, {18'd0, exp_pair(disp[0])});
    chk("single_others_blank", {4'd0, obs_pair(2), obs_pair(1)}, {4'd0, 14'h3FFF, 14'h3FFF});

    // Clamping and leading zero
    foreach (v2_tab[i]) begin end
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 32'd150 : (i == 1) ? 32'h0001_0005 : 32'd5;
      do_write(1, v);
      repeat (10) @(posedge clock); #1;
      disp[1] = clamp(v);
      chk("clamp_hex32", {18'd0, obs_pair(1)}, {18'd0, exp_pair(disp[1])});
      chk("clamp_rdata", rdata, v);
    end

    // Priority: p2 already loading when p0 is written
    do_write(2, 32'd12);
    do_write(0, 32'd0);
    upd = -1; upd2 = -1;
    for (int j = 2; j <= 24; j++) begin
      @(posedge clock); #1;
      if (upd < 0 && obs_pair(2) === exp_pair(12)) upd = j;
      if (upd2 < 0 && obs_pair(0) === exp_pair(0)) upd2 = j;
    end
    disp[2] = 12; disp[0] = 0;
    chk("prio_p2_edge", upd, 9);
    chk("prio_p0_edge", upd2, 19);
    chk("prio_hex54", {18'd0, obs_pair(2)}, {18'd0, exp_pair(disp[2])});
    chk("prio_hex10", {18'd0, obs_pair(0)}, {18'd0, exp_pair(disp[0])});

    // Rewrite while converting
    do_write(0, 32'd11);
    repeat (2) @(posedge clock);
    do_write(0, 32'd88);
    upd = -1; upd2 = -1;
    for (int j = 4; j <= 26; j++) begin
      @(posedge clock); #1;
      if (upd < 0 && obs_pair(0) === exp_pair(11)) upd = j;
      if (upd2 < 0 && obs_pair(0) === exp_pair(88)) upd2 = j;
    end
    disp[0] = 88;
    chk("rewrite_first_edge", upd, 9);
    chk("rewrite_second_edge", upd2, 19);
    chk("rewrite_rdata", rdata, 32'd88);

    // Randomized stores, sometimes two back-to-back to the same port
    for (int n = 0; n < 16; n++) begin
      port = $urandom_range(0, 2);
      nwr = $urandom_range(1, 2);
      for (int w = 0; w < nwr; w++) begin
        v = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 120);
        do_write(port, v);
      end
      repeat (20) @(posedge clock); #1;
      disp[port] = clamp(v);
      chk("rand_hex", {18'd0, obs_pair(port)}, {18'd0, exp_pair(disp[port])});
      chk("rand_rdata", rdata, v);
      chk("rand_idle", {31'd0, busy}, 32'd0);
    end
    for (int i = 0; i < 3; i++) chk("rand_all_ports", {18'd0, obs_pair(i)}, {18'd0, exp_pair(disp[i])});

    // Reset in the middle of a conversion
    do_write(1, 32'd42);
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    disp = '{-1, -1, -1};
    chk_all_blank("midreset_hex");
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (15) @(posedge clock); #1;
    chk_all_blank("postreset_hex");
    chk("postreset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  int v2_tab [1];

endmodule

// File: doc/sc_io_hex_out.md
# sc_io_hex_out

Memory-mapped output peripheral for the single-cycle computer. It is the output side of the I/O path; the switch input ports are the input side. It captures CPU stores to three output-port addresses and converts each stored value to two decimal digits with a shared, iterative shift-add-3 (double-dabble) engine. It then drives six active-low 7-segment displays: port0 on hex1:hex0, port1 on hex3:hex2, port2 on hex5:hex4.

## Interface

Parameters:
- `ADDR_P0`, default 8'h80: word address byte of out_port0.
- `ADDR_P1`, default 8'h84: word address byte of out_port1.
- `ADDR_P2`, default 8'h88: word address byte of out_port2.

Ports:
- `clock`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `addr`  in  8: CPU data address bits [7:0].
- `wdata`  in  32: CPU store data.
- `wmem`  in  1: store strobe, sampled on rising `clock`.
- `rdata`  out  32: combinational read-back of the addressed port register; 0 for unmapped addresses.
- `busy`  out  1: converter active (LOAD/SHIFT/STORE).
- `hex0`..`hex5`  out  7 each: segment drive, active-low, bit order {g,f,e,d,c,b,a}.

## Operation

- Port registers `p0`/`p1`/`p2` (32 bits each) are written on the edge where `wmem`=1 and `addr` matches the port. Other addresses are ignored. A write sets that port's `pending[i]`.
- Displayed value: `wdata[31:0]` clamped to 0..99. Any value >99, including values with upper bits set, displays 99.
- FSM states: IDLE, LOAD, SHIFT, STORE.
  - IDLE: if any `pending` bit is set, go to LOAD and select the lowest pending index (p0 > p1 > p2 priority).
  - LOAD: clear the selected `pending`, capture the clamped 7-bit value into the shift register, clear the 8-bit BCD accumulator, set the iteration counter to 7.
  - SHIFT: one iteration per cycle. First add 3 to each BCD nibble ≥5, then shift {bcd,bin} left by 1 and decrement the counter. After the 7th iteration go to STORE.
  - STORE: write both digits to the selected port's display registers, then go to IDLE.
- A write to a port while that port is converting sets `pending` again. If the write lands in the same cycle as LOAD, the set wins over LOAD's clear. The in-flight conversion completes with the old value, and the new value is converted afterwards.
- Segment encoding (hex values): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. The tens digit is shown as "0" when the value is <10; there is no leading blank.

## Timing

Reset values:
- `p0`..`p2` = 0.
- `pending` = 0.
- FSM = IDLE.
- `busy` = 0.
- All `hex*` = 7'h7F (blank).
- `rdata` follows the reset registers, so it reads 0.

Write-to-display latency:
- Write at edge k. IDLE→LOAD at k+1. SHIFT at edges k+2..k+8. STORE at k+9.
- The new `hex` values are visible after edge k+9. IDLE is re-entered at k+10.
- Each conversion occupies 9 cycles of `busy`.

Queued writes:
- Back-to-back writes to different ports are serialized by priority, 10 cycles apart.
- A port written several times before its LOAD displays only the last value.

Reset:
- Asserting `reset` mid-conversion immediately blanks the displays and drops all pending work.
- Nothing resumes after reset deasserts.

`rdata`:
- Zero-latency: reflects the register value after the write edge.

## Test plan

- Reset: assert `reset` for 3 cycles -> all `hex*`=7F, `busy`=0, `rdata`=0 at every address.
- Single conversion: write 37 to 8'h80 -> `busy` high for 9 cycles; after edge k+9 `hex1`=30, `hex0`=78; `hex2`..`hex5` stay 7F; `rdata`@80 = 37.
- Clamping: write 150 to 8'h84 -> `hex3`=10, `hex2`=10 (99). Write 32'h0001_0005 -> 99. Write 5 -> `hex3`=40, `hex2`=12.
- Priority and serialization: on consecutive cycles write p2=12, then p0=0 -> p2 converts first (already in LOAD), then p0. Final `hex5`/`hex4`=79/24, `hex1`/`hex0`=40/40.
- Rewrite during conversion: write p0=11, then write p0=88 three cycles later -> `hex1:0` shows 11 after 9 cycles, then 88 (00/00) about 10 cycles later.
- Mid-conversion reset: write p1=42, assert `reset` at cycle 4 -> displays stay 7F, `busy`=0, no update after reset release.
